// File: rtl/bumpy_pkg.sv
// Shared step types, grid geometry and the default level for the Bumpy playfield.
package bumpy_pkg;

  typedef enum logic [2:0] {
    FREE  = 3'd0,
    REGU  = 3'd1,
    GATE  = 3'd2,
    COIN  = 3'd3,
    WALL  = 3'd4,
    SPIKE = 3'd5,
    BRAKE = 3'd6
  } step_t;

  localparam int unsigned GRID_ROWS   = 7;
  localparam int unsigned GRID_COLS   = 10;
  localparam int unsigned GRID_TILE_W = 64;
  localparam int unsigned GRID_TILE_H = 68;

  localparam step_t DEFAULT_MAP [GRID_ROWS][GRID_COLS] = '{
    '{WALL, FREE, FREE,  FREE,  FREE,  FREE,  FREE,  FREE, FREE, GATE},
    '{FREE, REGU, REGU,  FREE,  SPIKE, FREE,  REGU,  REGU, FREE, FREE},
    '{FREE, FREE, FREE,  COIN,  FREE,  BRAKE, FREE,  FREE, WALL, FREE},
    '{REGU, FREE, SPIKE, REGU,  REGU,  FREE,  FREE,  GATE, FREE, REGU},
    '{FREE, WALL, FREE,  FREE,  FREE,  REGU,  FREE,  COIN, FREE, FREE},
    '{FREE, COIN, FREE,  BRAKE, FREE,  FREE,  SPIKE, FREE, REGU, FREE},
    '{REGU, REGU, REGU,  REGU,  REGU,  REGU,  REGU,  REGU, REGU, REGU}
  };

  // Row index by compare chain; returns GRID_ROWS when y is below the grid.
  function automatic logic [3:0] row_of(input logic [10:0] y, input logic [10:0] h);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = 1; i <= GRID_ROWS; i++) begin
      if (y >= 11'(i) * h) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/step_grid_map.sv
// Tile-map store, pixel-to-tile lookup and coin bookkeeping for the playfield.
// Define STEP_GRID_WRITE_EN to add the run-time tile write port.
module step_grid_map
  import bumpy_pkg::*;
#(
  parameter int unsigned NUM_OF_ROWS = GRID_ROWS,
  parameter int unsigned NUM_OF_COLS = GRID_COLS,
  parameter int unsigned TILE_WIDTH  = GRID_TILE_W,
  parameter int unsigned TILE_HEIGHT = GRID_TILE_H
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        levelLoad,
  input  logic        collectReq,
  input  logic [2:0]  collectRow,
  input  logic [3:0]  collectCol,
`ifdef STEP_GRID_WRITE_EN
  input  logic        wrReq,
  input  logic [2:0]  wrRow,
  input  logic [3:0]  wrCol,
  input  logic [2:0]  wrType,
`endif
  output logic [10:0] tileTopLeftX,
  output logic [10:0] tileTopLeftY,
  output logic [2:0]  step_type,
  output logic        collectAck,
  output logic        coinTaken,
  output logic [6:0]  coinsLeft,
  output logic        busy
);

  typedef enum logic {INIT, RUN} state_t;

  localparam int unsigned COL_SHIFT = $clog2(TILE_WIDTH);
  localparam logic [10:0] COLS11    = 11'(NUM_OF_COLS);
  localparam logic [3:0]  ROWS4     = 4'(NUM_OF_ROWS);
  localparam logic [10:0] TH11      = 11'(TILE_HEIGHT);
  localparam logic [2:0]  LAST_ROW  = 3'(NUM_OF_ROWS - 1);
  localparam logic [3:0]  LAST_COL  = 4'(NUM_OF_COLS - 1);

  state_t      state, state_n;
  logic [2:0]  init_row, init_row_n;
  logic [3:0]  init_col, init_col_n;
  step_t       map   [NUM_OF_ROWS][NUM_OF_COLS];
  step_t       map_n [NUM_OF_ROWS][NUM_OF_COLS];
  logic [6:0]  coins_n;
  logic        ack_n, taken_n, wr_hit;
  logic [10:0] col_w;
  logic [3:0]  row_w;
  logic        in_grid;
  logic [10:0] lk_x, lk_y;
  step_t       lk_t;

  assign busy = (state == INIT);

  always_comb begin
    state_n    = state;
    init_row_n = init_row;
    init_col_n = init_col;
    map_n      = map;
    coins_n    = coinsLeft;
    ack_n      = 1'b0;
    taken_n    = 1'b0;
    wr_hit     = 1'b0;
    if (levelLoad) begin
      state_n    = INIT;
      init_row_n = '0;
      init_col_n = '0;
      coins_n    = '0;
    end else if (state == INIT) begin
      map_n[init_row][init_col] = DEFAULT_MAP[init_row][init_col];
      if (DEFAULT_MAP[init_row][init_col] == COIN) coins_n = coinsLeft + 7'd1;
      if (init_col == LAST_COL) begin
        init_col_n = '0;
        if (init_row == LAST_ROW) begin
          init_row_n = '0;
          state_n    = RUN;
        end else begin
          init_row_n = init_row + 3'd1;
        end
      end else begin
        init_col_n = init_col + 4'd1;
      end
    end else begin
`ifdef STEP_GRID_WRITE_EN
      if (wrReq && (wrRow < ROWS4[2:0]) && (wrCol < COLS11[3:0])) begin
        wr_hit = 1'b1;
        map_n[wrRow][wrCol] = step_t'(wrType);
        if (map[wrRow][wrCol] == COIN && step_t'(wrType) != COIN)
          coins_n = coinsLeft - 7'd1;
        else if (map[wrRow][wrCol] != COIN && step_t'(wrType) == COIN)
          coins_n = coinsLeft + 7'd1;
      end
`endif
      // A same-cycle write owns the map, so the collect only gets a plain ack.
      if (collectReq) begin
        ack_n = 1'b1;
        if (!wr_hit && (collectRow < ROWS4[2:0]) && (collectCol < COLS11[3:0]) &&
            map[collectRow][collectCol] == COIN) begin
          map_n[collectRow][collectCol] = FREE;
          coins_n = coinsLeft - 7'd1;
          taken_n = 1'b1;
        end
      end
    end
  end

  // Lookup reads the post-edge map so same-edge updates are already visible.
  always_comb begin
    col_w   = pixelX >> COL_SHIFT;
    row_w   = row_of(pixelY, TH11);
    in_grid = (col_w < COLS11) && (row_w < ROWS4);
    lk_x    = '0;
    lk_y    = '0;
    lk_t    = FREE;
    if (in_grid) begin
      lk_x = col_w << COL_SHIFT;
      lk_y = {7'd0, row_w} * TH11;
      if (state == RUN) lk_t = map_n[row_w[2:0]][col_w[3:0]];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= INIT;
      init_row     <= '0;
      init_col     <= '0;
      for (int unsigned r = 0; r < NUM_OF_ROWS; r++)
        for (int unsigned c = 0; c < NUM_OF_COLS; c++)
          map[r][c] <= FREE;
      tileTopLeftX <= '0;
      tileTopLeftY <= '0;
      step_type    <= FREE;
      collectAck   <= 1'b0;
      coinTaken    <= 1'b0;
      coinsLeft    <= '0;
    end else begin
      state        <= state_n;
      init_row     <= init_row_n;
      init_col     <= init_col_n;
      map          <= map_n;
      tileTopLeftX <= lk_x;
      tileTopLeftY <= lk_y;
      step_type    <= lk_t;
      collectAck   <= ack_n;
      coinTaken    <= taken_n;
      coinsLeft    <= coins_n;
    end
  end

endmodule
